// File: rtl/ddr_cmd_scheduler.sv
// In-order, single-outstanding DDR command scheduler with open-page row tracking,
// one shared gap counter for tRCD/tRP/tCCD/tRFC, and periodic refresh insertion.
module ddr_cmd_scheduler #(
  parameter int ADDRWIDTH = 17,
  parameter int BANKS     = 8,
  parameter int BAWIDTH   = $clog2(BANKS),
  parameter int ROWBITS   = 9,
  parameter int COLBITS   = 9,
  parameter int TRCD      = 3,
  parameter int TRP       = 2,
  parameter int TCCD      = 2,
  parameter int TRFC      = 8,
  parameter int TREFI     = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BAWIDTH-1:0]   req_bank,
  input  logic [ROWBITS-1:0]   req_row,
  input  logic [COLBITS-1:0]   req_col,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] adr,
  output logic [BAWIDTH:0]     ba,
  output logic                 bg,
  output logic                 done,
  output logic                 done_write,
  output logic                 ref_busy
);

  localparam int GAP_A   = (TRCD > TRP) ? TRCD : TRP;
  localparam int GAP_B   = (TCCD > TRFC) ? TCCD : TRFC;
  localparam int GAP_MAX = (GAP_A > GAP_B) ? GAP_A : GAP_B;
  localparam int WW      = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam int RW      = $clog2(TREFI + 1);

  localparam logic [3:0] OP_ACT = 4'd1;
  localparam logic [3:0] OP_PR  = 4'd3;
  localparam logic [3:0] OP_RD  = 4'd4;
  localparam logic [3:0] OP_REF = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;

  typedef enum logic [2:0] {IDLE, PRE, ACT, CAS, REF_PRA, REF} state_t;

  state_t               state, state_nxt;
  logic                 ref_gap, ref_gap_nxt;
  logic [WW-1:0]        wait_cnt;
  logic [RW-1:0]        ref_cnt;
  logic                 ref_pending;

  logic                 lat_write;
  logic [BAWIDTH-1:0]   lat_bank;
  logic [ROWBITS-1:0]   lat_row;
  logic [COLBITS-1:0]   lat_col;

  logic [BANKS-1:0]     open_vld;
  logic [ROWBITS-1:0]   open_row [BANKS];

  logic                 accept, issue, set_open, clr_open, clr_all, ref_issue;
  logic [WW-1:0]        gap_load;
  logic                 any_open, row_hit;

  assign any_open   = |open_vld;
  assign row_hit    = open_vld[req_bank] && (open_row[req_bank] == req_row);
  assign bg         = 1'b0;
  assign done_write = lat_write;

  always_comb begin
    state_nxt   = state;
    ref_gap_nxt = ref_gap;
    req_ready   = 1'b0;
    accept      = 1'b0;
    issue       = 1'b0;
    gap_load    = '0;
    set_open    = 1'b0;
    clr_open    = 1'b0;
    clr_all     = 1'b0;
    ref_issue   = 1'b0;
    cs_n        = 1'b1;
    act_n       = 1'b1;
    adr         = '0;
    ba          = '0;
    done        = 1'b0;
    ref_busy    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !ref_pending;
        if (ref_pending) begin
          state_nxt = any_open ? REF_PRA : REF;
        end else if (req_valid) begin
          accept    = 1'b1;
          state_nxt = row_hit ? CAS : (open_vld[req_bank] ? PRE : ACT);
        end
      end
      PRE: begin
        if (wait_cnt == '0) begin
          issue                   = 1'b1;
          gap_load                = WW'(TRP - 1);
          cs_n                    = 1'b0;
          adr[ADDRWIDTH-1 -: 4]   = OP_PR;
          ba                      = {1'b0, lat_bank};
          clr_open                = 1'b1;
          state_nxt               = ACT;
        end
      end
      ACT: begin
        if (wait_cnt == '0) begin
          issue                   = 1'b1;
          gap_load                = WW'(TRCD - 1);
          cs_n                    = 1'b0;
          act_n                   = 1'b0;
          adr[ADDRWIDTH-1 -: 4]   = OP_ACT;
          adr[ROWBITS-1:0]        = lat_row;
          ba                      = {1'b0, lat_bank};
          set_open                = 1'b1;
          state_nxt               = CAS;
        end
      end
      CAS: begin
        if (wait_cnt == '0) begin
          issue                   = 1'b1;
          gap_load                = WW'(TCCD - 1);
          cs_n                    = 1'b0;
          adr[ADDRWIDTH-1 -: 4]   = lat_write ? OP_WR : OP_RD;
          adr[COLBITS-1:0]        = lat_col;
          ba                      = {1'b0, lat_bank};
          done                    = 1'b1;
          state_nxt               = IDLE;
        end
      end
      REF_PRA: begin
        ref_busy = 1'b1;
        if (wait_cnt == '0) begin
          issue                   = 1'b1;
          gap_load                = WW'(TRP - 1);
          cs_n                    = 1'b0;
          adr[ADDRWIDTH-1 -: 4]   = OP_PR;
          adr[10]                 = 1'b1;
          clr_all                 = 1'b1;
          state_nxt               = REF;
        end
      end
      REF: begin
        ref_busy = 1'b1;
        // After REF the FSM lingers here so req_ready stays low through tRFC;
        // it leaves one cycle early so IDLE coincides with wait_cnt reaching 0.
        if (ref_gap) begin
          if (wait_cnt <= WW'(1)) begin
            state_nxt   = IDLE;
            ref_gap_nxt = 1'b0;
          end
        end else if (wait_cnt == '0) begin
          issue                   = 1'b1;
          gap_load                = WW'(TRFC - 1);
          cs_n                    = 1'b0;
          adr[ADDRWIDTH-1 -: 4]   = OP_REF;
          ref_issue               = 1'b1;
          if (TRFC == 1) state_nxt = IDLE;
          else           ref_gap_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ref_gap     <= 1'b0;
      wait_cnt    <= '0;
      ref_cnt     <= RW'(TREFI);
      ref_pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      ref_gap <= ref_gap_nxt;
      if (issue)               wait_cnt <= gap_load;
      else if (wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
      if (ref_cnt == RW'(1)) ref_cnt <= RW'(TREFI);
      else                   ref_cnt <= ref_cnt - RW'(1);
      // A new expiry wins over the clear so a refresh is never lost.
      if (ref_cnt == RW'(1)) ref_pending <= 1'b1;
      else if (ref_issue)    ref_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_bank  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      open_vld  <= '0;
      for (int unsigned i = 0; i < BANKS; i++) open_row[i] <= '0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_bank  <= req_bank;
        lat_row   <= req_row;
        lat_col   <= req_col;
      end
      if (clr_all)  open_vld <= '0;
      if (clr_open) open_vld[lat_bank] <= 1'b0;
      if (set_open) begin
        open_vld[lat_bank] <= 1'b1;
        open_row[lat_bank] <= lat_row;
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: command timing, row policy, refresh and reset abort.
module tb_ddr_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_bank = '0;
  logic [8:0]  req_row = '0;
  logic [8:0]  req_col = '0;
  logic        cs_n, act_n, bg, done, done_write, ref_busy;
  logic [16:0] adr;
  logic [3:0]  ba;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  ddr_cmd_scheduler #(
    .ADDRWIDTH(17), .BANKS(8), .ROWBITS(9), .COLBITS(9),
    .TRCD(3), .TRP(2), .TCCD(2), .TRFC(8), .TREFI(100)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cs_n(cs_n), .act_n(act_n), .adr(adr), .ba(ba), .bg(bg),
    .done(done), .done_write(done_write), .ref_busy(ref_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present a request now and hold it until accepted; returns the accept cycle.
  task automatic send(input logic w, input logic [2:0] b, input logic [8:0] r,
                      input logic [8:0] c, output int acc);
    req_write = w; req_bank = b; req_row = r; req_col = c; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Step negedges until a command cycle; leaves time at that negedge.
  task automatic wait_cmd(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!cs_n) begin
        c = cyc;
        return;
      end
    end
    check("cmd_timeout", 0, 1);
  endtask

  initial begin
    int n, c, p, e2, r;
    logic saw_done;

    #12;
    check("rst_cs_n", cs_n, 1);
    check("rst_act_n", act_n, 1);
    check("rst_adr", adr, 0);
    check("rst_ba", ba, 0);
    check("rst_bg", bg, 0);
    check("rst_done", done, 0);
    check("rst_ref_busy", ref_busy, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("idle_ready", req_ready, 1);

    // 1: closed bank -> ACT at N+1, RD at N+4
    send(1'b0, 3'd2, 9'd5, 9'd7, n);
    wait_cmd(20, c);
    check("t1_act_cyc", c, n + 1);
    check("t1_act_n", act_n, 0);
    check("t1_act_adr", adr, 17'h02005);
    check("t1_act_ba", ba, 2);
    check("t1_act_done", done, 0);
    wait_cmd(20, c);
    check("t1_rd_cyc", c, n + 4);
    check("t1_rd_adr", adr, 17'h08007);
    check("t1_rd_done", done, 1);
    check("t1_rd_dw", done_write, 0);
    p = c;

    // 2: row hit write -> WR at max(N+1, CAS+2)
    send(1'b1, 3'd2, 9'd5, 9'd9, n);
    wait_cmd(20, c);
    check("t2_wr_cyc", c, (n + 1 > p + 2) ? n + 1 : p + 2);
    check("t2_wr_act_n", act_n, 1);
    check("t2_wr_adr", adr, 17'h0C009);
    check("t2_wr_done", done, 1);
    check("t2_wr_dw", done_write, 1);

    // 3: row conflict -> PR N+1, ACT N+3, RD N+6
    send(1'b0, 3'd2, 9'd6, 9'd3, n);
    wait_cmd(20, c);
    check("t3_pr_cyc", c, n + 1);
    check("t3_pr_adr", adr, 17'h06000);
    check("t3_pr_ba", ba, 2);
    wait_cmd(20, c);
    check("t3_act_cyc", c, n + 3);
    check("t3_act_adr", adr, 17'h02006);
    wait_cmd(20, c);
    check("t3_rd_cyc", c, n + 6);
    check("t3_rd_adr", adr, 17'h08003);
    check("t3_rd_done", done, 1);

    // 4: periodic refresh with bank 2 open
    wait_cmd(200, p);
    check("t4_pra_adr", adr, 17'h06400);
    check("t4_pra_ba", ba, 0);
    check("t4_pra_busy", ref_busy, 1);
    check("t4_pra_ready", req_ready, 0);
    wait_cmd(20, r);
    check("t4_ref_cyc", r, p + 2);
    check("t4_ref_adr", adr, 17'h0A000);
    repeat (7) @(negedge clk);
    check("t4_ready_trfc7", req_ready, 0);
    check("t4_busy_trfc7", ref_busy, 1);
    @(negedge clk);
    check("t4_ready_trfc8", req_ready, 1);
    check("t4_busy_trfc8", ref_busy, 0);
    send(1'b0, 3'd2, 9'd6, 9'd1, n);
    wait_cmd(20, c);
    check("t4_reopen_cyc", c, n + 1);
    check("t4_reopen_act_n", act_n, 0);
    check("t4_reopen_adr", adr, 17'h02006);
    wait_cmd(20, c);
    check("t4_rd_cyc", c, n + 4);
    check("t4_rd_adr", adr, 17'h08001);

    // 5: next expiry lands TREFI cycles after the previous one (PRA at p = expiry+1)
    e2 = p + 99;
    for (int i = 0; i < 200 && cyc < e2 - 1; i++) @(negedge clk);
    check("t5_ready_pre", req_ready, 1);
    @(posedge clk);
    #1;
    req_write = 1'b1; req_bank = 3'd5; req_row = 9'h1AB; req_col = 9'h00F; req_valid = 1'b1;
    check("t5_ready_expiry", req_ready, 0);
    wait_cmd(20, c);
    check("t5_pra_cyc", c, e2 + 1);
    check("t5_pra_adr", adr, 17'h06400);
    wait_cmd(20, c);
    check("t5_ref_cyc", c, e2 + 3);
    check("t5_ref_adr", adr, 17'h0A000);
    wait_cmd(30, c);
    req_valid = 1'b0;
    check("t5_act_cyc", c, e2 + 12);
    check("t5_act_adr", adr, 17'h021AB);
    check("t5_act_ba", ba, 5);
    wait_cmd(20, c);
    check("t5_wr_cyc", c, e2 + 15);
    check("t5_wr_adr", adr, 17'h0C00F);
    check("t5_wr_dw", done_write, 1);

    // 6: reset between ACT and RD aborts the request
    @(negedge clk);
    send(1'b0, 3'd3, 9'd4, 9'd2, n);
    wait_cmd(20, c);
    check("t6_act_cyc", c, n + 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_cs_n", cs_n, 1);
    check("t6_rst_adr", adr, 0);
    check("t6_rst_done", done, 0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("t6_no_done", saw_done, 0);
    send(1'b0, 3'd3, 9'd4, 9'd2, n);
    wait_cmd(20, c);
    check("t6_react_cyc", c, n + 1);
    check("t6_react_act_n", act_n, 0);
    check("t6_react_adr", adr, 17'h02004);
    wait_cmd(20, c);
    check("t6_rd_cyc", c, n + 4);
    check("t6_rd_adr", adr, 17'h08002);
    check("t6_rd_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_scheduler.md
Name: ddr_cmd_scheduler

Overview:
- In-order, single-outstanding command scheduler in front of the emulated DIMM.
- Accepts read/write requests (bank, row, column) and tracks the open row of every bank.
- Issues ACT/PR/RD/WR/REF on the DIMM command pins, enforcing tRCD, tRP, tCCD and tRFC.
- Inserts periodic refresh every tREFI cycles. Sits between the host request port and the dimm command inputs, single bank group.

Parameters:
- ADDRWIDTH, 17, DIMM address bus width; top 4 bits carry the opcode.
- BANKS, 8, banks in the single bank group.
- BAWIDTH, $clog2(BANKS), bank index width.
- ROWBITS, 9, row address width; must be ≤ ADDRWIDTH-4.
- COLBITS, 9, column address width; must be ≤ ADDRWIDTH-4.
- TRCD, 3, ACT to RD/WR gap (cycles, ≥1).
- TRP, 2, PR to ACT/REF gap (≥1).
- TCCD, 2, RD/WR to next RD/WR gap (≥1).
- TRFC, 8, REF to any command gap (≥1).
- TREFI, 100, refresh interval (≥TRFC+TRP+2).

Ports:
- clk  in  1  scheduler clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_bank  in  BAWIDTH  target bank
- req_row  in  ROWBITS  target row
- req_col  in  COLBITS  target column
- cs_n  out  1  chip select, low only in command cycles
- act_n  out  1  low only in ACT cycles
- adr  out  ADDRWIDTH  opcode[ADDRWIDTH-1:ADDRWIDTH-4] plus operand
- ba  out  BAWIDTH+1  bank (MSB always 0)
- bg  out  1  bank group, tied 0
- done  out  1  one-cycle pulse in the RD/WR issue cycle
- done_write  out  1  copy of latched req_write, valid with done
- ref_busy  out  1  high from refresh start until the REF gap expires

Behaviour:
- Reset (async): all outputs idle; open-row table cleared (all banks closed); refresh down-counter = TREFI; ref_pending = 0; wait_cnt = 0; state IDLE.
- Idle bus values: cs_n=1, act_n=1, adr=0, ba=0, bg=0, done=0. Commands are driven for exactly one cycle.
- Opcodes: ACT=1, PR=3, RD=4, REF=5, WR=6. Operand sits in the low bits.
  - ACT: operand = row.
  - RD/WR: operand = column.
  - PR: adr[10]=0 means single bank ba; adr[10]=1 means all banks (PRA).
- Gap counter: issuing a command with gap T loads wait_cnt=T-1 for the next cycle, then decrements to 0 and saturates. A command may issue only in a cycle with wait_cnt==0, so consecutive commands are ≥T cycles apart.
- States: IDLE, PRE, ACT, CAS, REF_PRA, REF.
- req_ready = (state==IDLE) && !ref_pending. Acceptance latches all req_* fields.
- Accept in cycle N, next state by latched request:
  - Row hit: CAS.
  - Bank closed: ACT.
  - Open with another row: PRE.
- PRE issues PR(bank) at the first legal cycle ≥N+1, marks the bank closed, then goes to ACT.
- ACT issues, records the row as open, then goes to CAS.
- CAS issues RD/WR (gap TCCD) with done=1 and done_write, then returns to IDLE.
- Resulting CAS times with no prior gap pending:
  - hit: N+1
  - closed bank: N+1+TRCD
  - row conflict: N+1+TRP+TRCD
- Rows stay open after CAS (open-page policy).
- Refresh:
  - The counter decrements every cycle. At 1 it sets ref_pending and reloads TREFI.
  - Further expiries while pending are absorbed; only one refresh is owed.
  - Refresh never interrupts a request in flight; it starts from IDLE and takes priority over req_valid in that cycle.
  - If any bank is open: REF_PRA issues PR with adr[10]=1 (gap TRP) and clears the table. Then REF issues (gap TRFC).
  - ref_pending clears at REF issue. ref_busy is high from leaving IDLE for refresh until wait_cnt returns to 0 after REF.
- Simultaneous refresh expiry and req_valid in IDLE: refresh wins, and req_ready is already low that cycle.
- Gaps are tracked by one shared counter, so the timing is conservative across banks.
- Reset mid-operation aborts any command sequence. No done is produced for the aborted request.

Test Plan:
1. TRCD=3: reset, then read bank 2 row 5 col 7 accepted at N → ACT (adr opcode 1, row 5, ba=2, act_n=0) at N+1; RD (opcode 4, col 7) at N+4 with done=1, done_write=0.
2. Repeat write to bank 2 row 5 col 9 → no ACT; WR at acceptance+1, or at the prior CAS+TCCD if later (CAS+2 with TCCD=2); done_write=1.
3. TRP=2, TRCD=3: read bank 2 row 6 after row 5 is open → PR(ba=2, adr[10]=0) at N+1, ACT row 6 at N+3, RD at N+6.
4. TREFI=100 with bank 2 open, no traffic → PR with adr[10]=1, REF (opcode 5) TRP=2 cycles later. req_ready low until TRFC=8 cycles after REF. The next access to bank 2 needs an ACT.
5. Refresh expiry in the same cycle as req_valid in IDLE → refresh sequence first; the request is accepted afterwards and completes normally.
6. Assert rst between ACT and RD → outputs idle immediately, no done, table cleared; a later read to the same row issues an ACT.
